// File: rtl/nukv_col_block_packer_pkg.sv
// Shared constants, drain state encoding and column extraction for the row->column packer.
package nukv_col_block_packer_pkg;

    localparam int COL_W        = 32;
    localparam int NUM_COLS     = 3;
    localparam int ROWS_PER_BLK = 16;
    localparam int ROW_W        = COL_W * NUM_COLS;   // 96
    localparam int WORD_W       = COL_W * ROWS_PER_BLK; // 512
    localparam int IDX_W        = 4;                  // row index inside a bank
    localparam int CNT_W        = 5;                  // 1..16 valid rows

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } drain_state_t;

    // Pick one 32-bit column value out of a 96-bit row; column 3 never occurs.
    function automatic logic [COL_W-1:0] col_select(input logic [ROW_W-1:0] row,
                                                    input logic [1:0]       col);
        case (col)
            2'd1:    return row[2*COL_W-1:COL_W];
            2'd2:    return row[3*COL_W-1:2*COL_W];
            default: return row[COL_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/nukv_col_block_bank.sv
// One 16x96 row bank: row-indexed write, column-transposed read with rows >= count forced to zero.
module nukv_col_block_bank
    import nukv_col_block_packer_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic [1:0]        rd_col,
    input  logic [CNT_W-1:0]  rd_count,
    output logic [WORD_W-1:0] rd_word
);

    // Row storage is deliberately not reset; stale rows are hidden by the count mask.
    logic [ROW_W-1:0] mem [ROWS_PER_BLK];

    // Capture one row per accepted input beat.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // Lane r of the column word is column rd_col of row r, zero past the block's row count.
    for (genvar r = 0; r < ROWS_PER_BLK; r++) begin : g_lane
        assign rd_word[r*COL_W +: COL_W] =
            (CNT_W'(r) < rd_count) ? col_select(mem[r], rd_col) : '0;
    end

endmodule

// File: rtl/nukv_col_block_packer.sv
// Ping-pong transposer: fills 16-row blocks of 96-bit rows, drains each as 3 column-major 512-bit words.
module nukv_col_block_packer
    import nukv_col_block_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROW_W-1:0]  input_data,
    input  logic              input_valid,
    input  logic              input_last,
    output logic              input_ready,
    output logic [WORD_W-1:0] output_data,
    output logic              output_valid,
    output logic              output_last,
    output logic [CNT_W-1:0]  output_rows,
    input  logic              output_ready
);

    logic                        fill_bank;
    logic                        drain_bank;
    logic [IDX_W-1:0]            fill_cnt;
    logic [1:0]                  full;
    logic [1:0]                  last_flag;
    logic [1:0][CNT_W-1:0]       count;
    logic [1:0][WORD_W-1:0]      bank_word;

    drain_state_t                state, state_nxt;
    logic [1:0]                  col, col_nxt;
    logic                        load;
    logic                        rd_bank;
    logic [1:0]                  rd_col;

    logic in_hs, blk_close, out_hs, release_blk;

    assign input_ready = !full[fill_bank];
    assign in_hs       = input_valid && input_ready;
    assign blk_close   = in_hs && (fill_cnt == IDX_W'(ROWS_PER_BLK-1) || input_last);
    assign out_hs      = output_valid && output_ready;
    assign release_blk = (state == ST_EMIT) && out_hs && (col == 2'd2);

    // Both banks share the read column; the drain mux below picks which bank's word is loaded.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        nukv_col_block_bank u_bank (
            .clk      (clk),
            .wr_en    (in_hs && (fill_bank == 1'(b))),
            .wr_idx   (fill_cnt),
            .wr_data  (input_data),
            .rd_col   (rd_col),
            .rd_count (count[b]),
            .rd_word  (bank_word[b])
        );
    end

    // Fill side bookkeeping; a close and a release always target different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_bank <= 1'b0;
            fill_cnt  <= '0;
            full      <= '0;
            last_flag <= '0;
            count     <= '0;
        end else begin
            if (in_hs) begin
                if (blk_close) begin
                    full[fill_bank]      <= 1'b1;
                    count[fill_bank]     <= {1'b0, fill_cnt} + CNT_W'(1);
                    last_flag[fill_bank] <= input_last;
                    fill_cnt             <= '0;
                    fill_bank            <= !fill_bank;
                end else begin
                    fill_cnt <= fill_cnt + IDX_W'(1);
                end
            end
            if (release_blk) full[drain_bank] <= 1'b0;
        end
    end

    // Drain next-state: decide whether a new column word is loaded and from which bank/column.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        load      = 1'b0;
        rd_bank   = drain_bank;
        rd_col    = 2'd0;
        case (state)
            ST_IDLE: begin
                if (full[drain_bank]) begin
                    load      = 1'b1;
                    state_nxt = ST_EMIT;
                    col_nxt   = 2'd0;
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    if (col != 2'd2) begin
                        load    = 1'b1;
                        rd_col  = col + 2'd1;
                        col_nxt = col + 2'd1;
                    end else if (full[!drain_bank]) begin
                        // Other bank already waiting: start it now so no bubble appears.
                        load    = 1'b1;
                        rd_bank = !drain_bank;
                        col_nxt = 2'd0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Drain state and output register; outputs only move on a load or a final handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            col          <= 2'd0;
            drain_bank   <= 1'b0;
            output_data  <= '0;
            output_valid <= 1'b0;
            output_last  <= 1'b0;
            output_rows  <= '0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            drain_bank <= drain_bank ^ release_blk;
            if (load) begin
                output_data  <= bank_word[rd_bank];
                output_valid <= 1'b1;
                output_last  <= last_flag[rd_bank] && (rd_col == 2'd2);
                output_rows  <= count[rd_bank];
            end else if (release_blk) begin
                output_valid <= 1'b0;
                output_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nukv_col_block_packer.sv
// Directed + randomized bench with a block-level reference model of the row->column packer.
module tb_nukv_col_block_packer;

    logic         clk;
    logic         rst;
    logic [95:0]  input_data;
    logic         input_valid;
    logic         input_last;
    logic         input_ready;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_last;
    logic [4:0]   output_rows;
    logic         output_ready;

    nukv_col_block_packer dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_last   (input_last),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_last  (output_last),
        .output_rows  (output_rows),
        .output_ready (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic [4:0]   rows;
        logic         last;
    } word_t;

    word_t       exp_q[$];
    logic [95:0] cur_rows[$];
    int          errors = 0;
    int          checks = 0;
    int          rdy_mode = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: collect rows into a block; on 16 rows or last, emit 3 transposed words.
    task automatic model_row(input logic [95:0] d, input logic l);
        word_t w;
        cur_rows.push_back(d);
        if (cur_rows.size() == 16 || l) begin
            for (int c = 0; c < 3; c++) begin
                w.data = '0;
                for (int r = 0; r < cur_rows.size(); r++)
                    w.data[r*32 +: 32] = cur_rows[r][c*32 +: 32];
                w.rows = 5'(cur_rows.size());
                w.last = l && (c == 2);
                exp_q.push_back(w);
            end
            cur_rows.delete();
        end
    endtask

    // Monitor: record accepted rows, compare every valid output word against the model front.
    always @(negedge clk) begin
        if (rst) begin
            if (input_valid && input_ready) model_row(input_data, input_last);
            if (output_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 512'(output_valid), 512'(0));
                end else begin
                    chk("word_data", output_data, exp_q[0].data);
                    chk("word_rows", 512'(output_rows), 512'(exp_q[0].rows));
                    chk("word_last", 512'(output_last), 512'(exp_q[0].last));
                    if (output_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Random back-pressure generator, active only in mode 2.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 2) output_ready = 1'($urandom_range(0, 1));
    end

    task automatic set_rdy(input int m);
        rdy_mode = m;
        if (m < 2) output_ready = (m == 1);
    endtask

    task automatic send_row(input logic [95:0] d, input logic l);
        logic acc;
        int   guard;
        guard = 0;
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        do begin
            @(negedge clk);
            acc = input_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("send_timeout", 512'(acc), 512'(1));
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int  guard;
        logic done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 1000) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !output_valid;
            guard++;
        end
        chk("drain_complete", 512'(done), 512'(1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rnd_row();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int   idx;
        int   n;
        logic acc;
        logic seen;

        rst = 1'b0; input_data = '0; input_valid = 1'b0; input_last = 1'b0; output_ready = 1'b0;
        #12;
        chk("rst_valid", 512'(output_valid), 512'(0));
        chk("rst_last",  512'(output_last),  512'(0));
        chk("rst_rows",  512'(output_rows),  512'(0));
        chk("rst_data",  output_data,        512'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rst_ready", 512'(input_ready), 512'(1));

        // Full 16-row block with recognisable lanes.
        set_rdy(1);
        for (int r = 0; r < 16; r++) send_row({32'h200 + r, 32'h100 + r, 32'(r)}, r == 15);
        wait_drain();

        // Short packet: masking of lanes 5..15.
        for (int r = 0; r < 5; r++) send_row({32'h200 + r, 32'h100 + r, 32'(r)}, r == 4);
        wait_drain();

        // Back-pressure: both banks fill, then the 33rd row stalls.
        set_rdy(0);
        idx = 0;
        input_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            input_data = {32'hB000 + idx, 32'hA000 + idx, 32'(idx)};
            input_last = 1'b0;
            @(negedge clk);
            acc = input_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        input_valid = 1'b0;
        chk("bp_accepted", 512'(idx), 512'(32));
        chk("bp_ready_low", 512'(input_ready), 512'(0));
        set_rdy(1);
        seen = 1'b0;
        for (int g = 0; g < 50 && !seen; g++) begin
            @(negedge clk);
            seen = input_ready;
        end
        chk("bp_ready_back", 512'(seen), 512'(1));
        @(posedge clk); #1;
        for (int r = 32; r < 48; r++) send_row({32'hB000 + r, 32'hA000 + r, 32'(r)}, r == 47);
        wait_drain();

        // Back-to-back 16+1 rows: 6 words with no bubble.
        for (int r = 0; r < 17; r++) send_row(rnd_row(), r == 16);
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            seen = output_valid;
        end
        chk("b2b_first_valid", 512'(seen), 512'(1));
        chk("b2b_valid_0", 512'(output_valid), 512'(1));
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk("b2b_no_bubble", 512'(output_valid), 512'(1));
        end
        @(posedge clk); #1;
        wait_drain();

        // Random stalls during emission with random packet lengths.
        set_rdy(2);
        for (int p = 0; p < 4; p++) begin
            n = $urandom_range(1, 20);
            for (int r = 0; r < n; r++) send_row(rnd_row(), r == n - 1);
        end
        wait_drain();

        // Single-row packets.
        set_rdy(1);
        for (int p = 0; p < 4; p++) send_row(rnd_row(), 1'b1);
        wait_drain();

        // Async reset mid-way through block 2 fill while block 1 is held on the output.
        set_rdy(0);
        for (int r = 0; r < 20; r++) send_row(rnd_row(), 1'b0);
        chk("pre_rst_valid", 512'(output_valid), 512'(1));
        #2;
        rst = 1'b0;
        exp_q.delete();
        cur_rows.delete();
        #1;
        chk("async_rst_valid", 512'(output_valid), 512'(0));
        chk("async_rst_rows",  512'(output_rows),  512'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        chk("post_rst_ready", 512'(input_ready), 512'(1));
        set_rdy(1);
        for (int r = 0; r < 3; r++) send_row(rnd_row(), r == 2);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nukv_col_block_packer.md
Name: nukv_col_block_packer

Overview:
- Reverse direction of the column-to-row unpacker in the rotation path.
- Accepts a stream of 96-bit rows (3 × 32-bit column values, one row per beat) and transposes them into column-major 512-bit words.
- Each block of up to 16 rows is emitted as 3 output words: word c carries column c of rows 0..15.
- Sits between the row-level processing stage and the 512-bit memory/network write path.

Parameters:
- COL_W, 32, width of one column value; fixed, block assumes 32.
- NUM_COLS, 3, columns per row.
- ROWS_PER_BLK, 16, rows per block; equals 512/COL_W.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_data  input  96  row; bits [32*c+31:32*c] = column c.
- input_valid  input  1  row present.
- input_last  input  1  final row of packet; only meaningful with input_valid.
- input_ready  output  1  row accepted when input_valid && input_ready.
- output_data  output  512  column word; bits [32*r+31:32*r] = row r of current column.
- output_valid  output  1  word present.
- output_last  output  1  set on column-2 word of the packet's final block.
- output_rows  output  5  valid rows in current block, 1..16, constant for all 3 words of a block.
- output_ready  input  1  word consumed when output_valid && output_ready.

Behaviour:
- Storage: two banks (ping-pong), each 16 × 96 bits, plus per bank: full flag, row count (5 b), last flag.
- Fill side writes the fill bank at row index fill_cnt (4 b).
  - input_ready = !full[fill_bank].
  - On handshake: store row, fill_cnt++.
  - Block closes when fill_cnt==15 or input_last=1. On close: full[fill_bank]<=1, count<=fill_cnt+1, last flag<=input_last, fill_cnt<=0, fill_bank toggles.
- Drain side reads the drain bank. States: IDLE, EMIT.
  - IDLE: when full[drain_bank]=1, load output register with column 0 and go to EMIT with col=0.
  - EMIT: hold output_data/output_valid/output_last/output_rows stable while output_ready=0.
  - On handshake with col<2: load column col+1 next cycle.
  - On handshake with col==2: clear full[drain_bank], toggle drain_bank. If the other bank is already full, load its column 0 in the same cycle (no bubble); else return to IDLE.
- Rows r ≥ count are driven zero in output_data.
- output_last = last flag && col==2; output_rows = bank count.
- Latency: 1 cycle from block close to output_valid=1 for column 0, when the drain side is idle.
- Throughput:
  - Input sustains 1 row/cycle; output needs 3 of every 16 cycles for full blocks.
  - Back-pressure reaches input only when both banks are full.
  - A stream of single-row packets bottlenecks at 3 output cycles per row.
- Simultaneous close and drain-release of the same bank cannot occur, since fill only targets a non-full bank. Close of bank A and release of bank B in the same cycle are both honoured.
- Reset values (asynchronous, active-low):
  - output_valid=0, output_last=0, output_rows=0, output_data=0, input_ready=1 after release.
  - All full flags, counters and bank pointers 0; state IDLE.
  - Bank contents are not reset.
- Reset mid-block discards partially filled and pending blocks; no partial output is emitted.
- input_last with input_valid=0 is ignored. There are no empty packets: every close carries ≥1 row.

Decomposition:
- Shared package holds: COL_W, NUM_COLS, ROWS_PER_BLK, ROW_W=96, WORD_W=512, the drain state enum, and a column-select helper function.
- One natural sub-module, nukv_col_block_bank: a single 16×96 bank with write port (row index) and column-select read producing a 512-bit column word with zero masking beyond count. It is instantiated twice.

Test Plan:
- Full block: 16 rows, row r = {32'h200+r, 32'h100+r, r}, last on row 15, output_ready=1 → 3 words:
  - word0 lanes = 0..15;
  - word1 lanes = 0x100..0x10F;
  - word2 lanes = 0x200..0x20F;
  - output_rows=16; output_last only on word2.
- Short packet: 5 rows with last on row 4 → output_rows=5, lanes 5..15 = 0 in all 3 words, output_last on word2.
- Back-pressure:
  - Stream 48 rows continuously with output_ready held 0 → input_ready drops after row 32 is accepted (both banks full).
  - Release output_ready → 9 words in order, no duplicates or losses; input_ready returns 1 after the first block drains.
- Stall stability: toggle output_ready randomly during EMIT → output_data/output_rows/output_last unchanged while valid && !ready.
- Back-to-back: 17 rows, last on row 16 → block 1 has rows=16 with output_last=0 on all words; block 2 has rows=1 with lane0 = row 16 and output_last=1; drain_bank switch occurs without a bubble cycle.
- Async reset: assert rst=0 mid-way through block 2 fill, between clock edges → output_valid=0 immediately. After release, a fresh 3-row packet emits only its own data with output_rows=3.
